// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, address+R/W, one data byte, ACK handling, STOP.
// Each SCL bit is four quarters of CLK_DIV clk cycles; sda/scl are open-drain.
module i2c_master_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        sda,
  inout  wire        scl
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START_C, ADDR, ADDR_ACK, WRITE_DATA, DATA_ACK,
    READ_DATA, M_NACK, STOP_C, DONE
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [7:0]    wdata;
  logic          rw_q;
  logic          sda_bit;
  logic          tick, bit_end, sample;
  logic          sda_low, scl_low;
  logic          sda_in;

  assign sda    = sda_low ? 1'b0 : 1'bz;
  assign scl    = scl_low ? 1'b0 : 1'bz;
  assign sda_in = sda;

  always_comb begin
    tick       = (cnt == DIV_MAX);
    bit_end    = tick && (q == 2'd3);
    sample     = (cnt == '0) && (q == 2'd2);
    state_next = state;
    sda_low    = 1'b0;
    scl_low    = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = START_C;
      START_C: begin
        // SDA falls at q1 while SCL is still released, then SCL is pulled low at q3
        sda_low = (q != 2'd0);
        scl_low = (q == 2'd3);
        if (bit_end) state_next = ADDR;
      end
      ADDR: begin
        sda_low = ~shreg[7];
        scl_low = (q < 2'd2);
        if (bit_end && bit_cnt == 3'd0) state_next = ADDR_ACK;
      end
      ADDR_ACK: begin
        scl_low = (q < 2'd2);
        if (bit_end) state_next = sda_bit ? STOP_C : (rw_q ? READ_DATA : WRITE_DATA);
      end
      WRITE_DATA: begin
        sda_low = ~wdata[7];
        scl_low = (q < 2'd2);
        if (bit_end && bit_cnt == 3'd0) state_next = DATA_ACK;
      end
      DATA_ACK: begin
        scl_low = (q < 2'd2);
        if (bit_end) state_next = STOP_C;
      end
      READ_DATA: begin
        scl_low = (q < 2'd2);
        if (bit_end && bit_cnt == 3'd0) state_next = M_NACK;
      end
      M_NACK: begin
        scl_low = (q < 2'd2);
        if (bit_end) state_next = STOP_C;
      end
      STOP_C: begin
        sda_low = (q != 2'd3);
        scl_low = (q < 2'd2);
        if (bit_end) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      q        <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      wdata    <= '0;
      rw_q     <= 1'b0;
      sda_bit  <= 1'b1;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= (state == DONE);

      if (state == IDLE || state == DONE) begin
        cnt <= '0;
        q   <= '0;
      end else if (tick) begin
        cnt <= '0;
        q   <= q + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (state == IDLE && start) begin
        shreg   <= {addr, rw};
        wdata   <= data_in;
        rw_q    <= rw;
        ack_err <= 1'b0;
        busy    <= 1'b1;
      end
      if (state == DONE) busy <= 1'b0;

      if (state_next != state &&
          (state_next == ADDR || state_next == WRITE_DATA || state_next == READ_DATA))
        bit_cnt <= 3'd7;
      else if (bit_end && (state == ADDR || state == WRITE_DATA || state == READ_DATA))
        bit_cnt <= bit_cnt - 3'd1;

      if (bit_end && state == ADDR)       shreg <= {shreg[6:0], 1'b0};
      if (bit_end && state == WRITE_DATA) wdata <= {wdata[6:0], 1'b0};

      // The address shift register is reused to collect the read byte
      if (sample && (state == ADDR_ACK || state == DATA_ACK || state == READ_DATA))
        sda_bit <= sda_in;
      if (sample && state == READ_DATA)
        shreg <= {shreg[6:0], sda_in};
      if (state == READ_DATA && state_next == M_NACK)
        data_out <= shreg;

      if (bit_end && sda_bit && (state == ADDR_ACK || state == DATA_ACK))
        ack_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Bench for i2c_master_controller: two masters (CLK_DIV 4 and 1) share one bus
// with a sampled slave model at address 7'h2A; results checked via a scoreboard.
`timescale 1ns/1ps
module tb_i2c_master_controller;

  localparam logic [6:0] SLAVE_ADDR = 7'h2A;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s = 1'b0, start_f = 1'b0;
  logic [6:0] addr = '0;
  logic       rw = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out_s, data_out_f;
  logic       busy_s, busy_f, done_s, done_f, ack_err_s, ack_err_f;
  wire        sda, scl;
  logic       slv_low = 1'b0;

  pullup (sda);
  pullup (scl);
  assign sda = slv_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master_controller #(.CLK_DIV(4)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .addr(addr), .rw(rw), .data_in(data_in),
    .data_out(data_out_s), .busy(busy_s), .done(done_s), .ack_err(ack_err_s),
    .sda(sda), .scl(scl)
  );

  i2c_master_controller #(.CLK_DIV(1)) dut_f (
    .clk(clk), .rst(rst), .start(start_f), .addr(addr), .rw(rw), .data_in(data_in),
    .data_out(data_out_f), .busy(busy_f), .done(done_f), .ack_err(ack_err_f),
    .sda(sda), .scl(scl)
  );

  logic       fast_sel = 1'b0;
  logic       busy_x, done_x, ack_err_x;
  logic [7:0] data_out_x;
  assign busy_x     = fast_sel ? busy_f     : busy_s;
  assign done_x     = fast_sel ? done_f     : done_s;
  assign ack_err_x  = fast_sel ? ack_err_f  : ack_err_s;
  assign data_out_x = fast_sel ? data_out_f : data_out_s;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave / bus monitor, sampled once per clk away from the edge
  typedef enum logic [2:0] {M_IDLE, M_ADDR, M_AACK, M_WR, M_DACK, M_RD, M_MACK} mstate_t;
  mstate_t    mst = M_IDLE;
  logic       ps = 1'b1, pc = 1'b1, s, c;
  int         nb = 0, sent = 0, n_start = 0, n_stop = 0, dbits = 0;
  logic [7:0] sr = '0, txs = '0, tx_byte = '0, got_addr = '0, got_data = '0;
  logic       got_mack = 1'b0;

  always begin
    @(posedge clk);
    #1;
    s = sda;
    c = scl;
    if (pc && c && ps && !s) begin
      n_start++;
      mst = M_ADDR; nb = 0; sr = '0; slv_low = 1'b0;
    end else if (pc && c && !ps && s) begin
      n_stop++;
      mst = M_IDLE; slv_low = 1'b0;
    end else if (!pc && c) begin
      case (mst)
        M_ADDR: begin sr = {sr[6:0], s}; nb++; end
        M_WR:   begin sr = {sr[6:0], s}; nb++; dbits++; end
        M_RD:   dbits++;
        M_MACK: got_mack = s;
        default: ;
      endcase
    end else if (pc && !c) begin
      case (mst)
        M_ADDR: if (nb == 8) begin
          got_addr = sr;
          if (sr[7:1] == SLAVE_ADDR) begin slv_low = 1'b1; mst = M_AACK; end
          else mst = M_IDLE;
        end
        M_AACK: begin
          nb = 0; sr = '0;
          if (got_addr[0]) begin
            mst = M_RD; txs = tx_byte; slv_low = ~txs[7];
            txs = {txs[6:0], 1'b0}; sent = 1;
          end else begin
            mst = M_WR; slv_low = 1'b0;
          end
        end
        M_RD: if (sent == 8) begin
          slv_low = 1'b0; mst = M_MACK;
        end else begin
          slv_low = ~txs[7]; txs = {txs[6:0], 1'b0}; sent++;
        end
        M_WR: if (nb == 8) begin got_data = sr; slv_low = 1'b1; mst = M_DACK; end
        M_DACK, M_MACK: begin slv_low = 1'b0; mst = M_IDLE; end
        default: ;
      endcase
    end
    ps = s;
    pc = c;
  end

  typedef struct {
    logic [7:0]  abyte;
    logic [7:0]  wbyte;
    logic [7:0]  dout;
    logic        err;
    logic        rd;
    logic        acked;
    int unsigned lat;
    int unsigned dbits;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] dout_s = '0, dout_f = '0;

  task automatic run_txn(input bit fast, input logic [6:0] a, input logic r,
                         input logic [7:0] d, input logic [7:0] stx, input bit glitch);
    exp_t        e;
    int unsigned bp, c0, lat;
    bit          seen;
    bp      = fast ? 4 : 16;
    e.abyte = {a, r};
    e.acked = (a == SLAVE_ADDR);
    e.err   = !e.acked;
    e.rd    = r;
    e.wbyte = d;
    if (r && e.acked) begin
      if (fast) dout_f = stx; else dout_s = stx;
    end
    e.dout  = fast ? dout_f : dout_s;
    e.lat   = (e.acked ? 20 : 11) * bp + 2;
    e.dbits = e.acked ? 8 : 0;
    sb.push_back(e);

    fast_sel = fast; tx_byte = stx;
    n_start = 0; n_stop = 0; dbits = 0; got_addr = '0; got_data = '0; got_mack = 1'b0;
    addr = a; rw = r; data_in = d;
    if (fast) start_f = 1'b1; else start_s = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start_f = 1'b0; start_s = 1'b0;
    check("busy_set", 32'(busy_x), 32'd1);
    check("ack_err_clr", 32'(ack_err_x), 32'd0);

    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(posedge clk); #1;
      if (glitch && i == 100) begin
        addr = 7'h01; rw = 1'b1; data_in = 8'h00;
        if (fast) start_f = 1'b1; else start_s = 1'b1;
      end
      if (glitch && i == 101) begin
        start_f = 1'b0; start_s = 1'b0;
        check("busy_hold", 32'(busy_x), 32'd1);
      end
      if (done_x) seen = 1'b1;
    end
    lat = cyc - c0;
    check("done_seen", 32'(seen), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("latency", lat, e.lat);
      check("ack_err", 32'(ack_err_x), 32'(e.err));
      check("data_out", 32'(data_out_x), 32'(e.dout));
      check("addr_byte", 32'(got_addr), 32'(e.abyte));
      check("n_start", n_start, 32'd1);
      check("n_stop", n_stop, 32'd1);
      check("data_bits", dbits, e.dbits);
      check("busy_clr", 32'(busy_x), 32'd0);
      if (e.acked && !e.rd) check("write_byte", 32'(got_data), 32'(e.wbyte));
      if (e.acked && e.rd)  check("master_nack", 32'(got_mack), 32'd1);
    end
    @(posedge clk); #1;
    check("done_pulse", 32'(done_x), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    int          nd;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_s", 32'(busy_s), 32'd0);
    check("rst_done_s", 32'(done_s), 32'd0);
    check("rst_ack_err_s", 32'(ack_err_s), 32'd0);
    check("rst_data_out_s", 32'(data_out_s), 32'd0);
    check("rst_data_out_f", 32'(data_out_f), 32'd0);
    check("rst_busy_f", 32'(busy_f), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_scl", 32'(scl), 32'd1);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    run_txn(1'b0, 7'h2A, 1'b0, 8'hA5, 8'h00, 1'b0);
    run_txn(1'b0, 7'h2A, 1'b1, 8'h00, 8'hCC, 1'b0);
    run_txn(1'b0, 7'h15, 1'b0, 8'h5A, 8'h00, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    check("ack_err_held", 32'(ack_err_s), 32'd1);
    run_txn(1'b0, 7'h2A, 1'b0, 8'h3F, 8'h00, 1'b1);

    // Abort during address bit 3, quarter 2
    fast_sel = 1'b0; addr = 7'h2A; rw = 1'b0; data_in = 8'hA5;
    start_s = 1'b1; c0 = cyc;
    @(posedge clk); #1;
    start_s = 1'b0;
    while (cyc < c0 + 89) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_sda", 32'(sda), 32'd1);
    check("abort_scl", 32'(scl), 32'd1);
    check("abort_busy", 32'(busy_s), 32'd0);
    check("abort_done", 32'(done_s), 32'd0);
    check("abort_data_out", 32'(data_out_s), 32'd0);
    rst = 1'b0;
    dout_s = '0; dout_f = '0;
    nd = 0;
    repeat (40) begin @(posedge clk); #1; if (done_s) nd++; end
    check("abort_no_done", nd, 32'd0);

    run_txn(1'b0, 7'h2A, 1'b0, 8'hA5, 8'h00, 1'b0);
    run_txn(1'b1, 7'h2A, 1'b0, 8'h3C, 8'h00, 1'b0);
    run_txn(1'b1, 7'h2A, 1'b1, 8'h00, 8'h5A, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_master_controller.md
Name: i2c_master_controller

Overview:
- Single-byte I2C master that generates START, address+R/W, one data byte, ACK handling and STOP on open-drain sda/scl.
- Sits directly upstream of i2c_slave_controller on the same two-wire bus, whose default slave address is 7'h2A.
- Driven by a local command interface: one transaction per start pulse, with a done pulse and an ack_err flag returned.

Parameters:
- CLK_DIV, 4: clk cycles per SCL quarter-period (must be >= 1). One bit period = 4*CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle command strobe; sampled only in IDLE
- addr  input  7  target slave address
- rw  input  1  0 = write data_in to slave, 1 = read one byte from slave
- data_in  input  8  write byte, captured with start
- data_out  output  8  read byte; valid when done pulses after a read
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse at transaction end, including error ends
- ack_err  output  1  high if the slave NACKed; held until the next accepted start
- sda  inout  1  open-drain: driven 0 or high-Z, never driven 1
- scl  inout  1  open-drain: driven 0 or high-Z, never driven 1

Behaviour:
- Reset values: sda/scl released (Z), busy 0, done 0, ack_err 0, data_out 8'h00, state IDLE, divider 0.
- Reset mid-transaction: lines are released on the next clk, with no STOP generated. The bench must tolerate the slave remaining in a started state.
- Quarter tick: a counter 0..CLK_DIV-1 produces a tick on wrap. The quarter index q advances 0..3 per tick.
- Per bit: SCL is low in q0–q1 and released in q2–q3. SDA changes only at q0. Sampling happens at the start of q2 (SCL high).
- Accepting start: in IDLE, start=1 latches {addr,rw} into a shift register, latches data_in, clears ack_err, sets busy and enters START_C.
- start while busy is ignored, with no side effects.
- States and transitions:
  - IDLE: both lines released.
  - START_C: one bit period. SCL is released; SDA is pulled low at q1 (SCL high); SCL is pulled low at q3. Then ADDR with bit counter = 7.
  - ADDR: shifts out {addr,rw} MSB first over 8 bits. Then ADDR_ACK.
  - ADDR_ACK: SDA released and sampled at q2. If low, go to WRITE_DATA if rw=0 or READ_DATA if rw=1. If high, set ack_err and go to STOP_C.
  - WRITE_DATA: shifts out 8 bits of the latched byte, MSB first. Then DATA_ACK.
  - DATA_ACK: SDA released and sampled. If high, set ack_err. Always go to STOP_C.
  - READ_DATA: SDA released; samples 8 bits MSB first into a shift register. Then M_NACK.
  - M_NACK: master releases SDA (NACK) for the 9th bit. data_out is updated from the shift register at entry. Then STOP_C.
  - STOP_C: one bit period. SDA is pulled low at q0 with SCL low; SCL is released at q2; SDA is released at q3 (rising SDA while SCL high). Then DONE.
  - DONE: done=1 for one clk, busy=0, return to IDLE.
- Latency from the accepted start to done:
  - full transaction: 20 bit periods (START 1 + 9 + 9 + STOP 1) plus 2 clk;
  - address-NACK transaction: 11 bit periods plus 2 clk.
- No clock stretching: the scl input is not sampled.
- No arbitration: single master only.
- data_out holds its value across write transactions and error transactions.

Test Plan:
- Write: CLK_DIV=4, addr=7'h2A, rw=0, data_in=8'hA5, slave ACKs both.
  - SDA bytes are 8'h54 then 8'hA5.
  - START/STOP edges occur while SCL is high.
  - done arrives 20*16+2 clk after start; ack_err=0.
- Read: addr=7'h2A, rw=1, slave drives 8'hCC.
  - data_out=8'hCC at done.
  - 9th data bit has SDA released (NACK); ack_err=0.
- Address NACK: addr=7'h15, no slave responds.
  - ack_err=1.
  - STOP follows the 9th bit; no data phase.
  - done arrives 11*16+2 clk after start.
- Busy rejection: a second start pulse with addr=7'h01 mid-transfer is ignored; the bus traffic matches the first command only.
- Reset mid-ADDR: rst is asserted during address bit 3.
  - Next clk: sda/scl are Z, busy=0, no done pulse.
  - A new write afterwards completes normally.
- CLK_DIV=1: write 8'h3C to 7'h2A.
  - Bit period is 4 clk.
  - Correct waveform; done arrives 82 clk after start.
